// File: rtl/pm_argmin_stream_pkg.sv
// Shared definitions for the path-metric argmin block and its neighbours
// (normalisation, traceback).
//   clog2      : ceiling log2, usable in constant expressions
//   DEF_*      : default configuration (7-bit metrics, 8 lanes, 8 beats)
//   vi_pair_t  : packed (value, index) pair at the default widths
//   beat_kind_e: how an incoming beat is treated by the input stage
package pm_argmin_stream_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    localparam int unsigned DEF_M          = 6;
    localparam int unsigned METRIC_W       = DEF_M + 1;
    localparam int unsigned DEF_LANES      = 8;
    localparam int unsigned DEF_LOG2_LANES = clog2(DEF_LANES);
    localparam int unsigned DEF_MAX_BEATS  = 8;
    // A zero-width beat field is not allowed; single-beat frames use 1 bit.
    localparam int unsigned DEF_BEAT_W     = (DEF_MAX_BEATS > 1) ? clog2(DEF_MAX_BEATS) : 1;
    localparam int unsigned DEF_IDX_W      = DEF_BEAT_W + DEF_LOG2_LANES;

    typedef struct packed {
        logic [METRIC_W-1:0]  value;
        logic [DEF_IDX_W-1:0] index;
    } vi_pair_t;

    typedef enum logic [1:0] {
        KIND_IDLE  = 2'd0,  // no beat this cycle
        KIND_FIRST = 2'd1,  // opens (or restarts) a frame
        KIND_NEXT  = 2'd2,  // continues the open frame
        KIND_DROP  = 2'd3   // non-first beat with no open frame
    } beat_kind_e;

endpackage

// File: rtl/pm_argmin_stream_if.sv
// Beat/result bundle of pm_argmin_stream.
//   in_valid/in_first/in_last : beat strobe and frame delimiters
//   in_metrics                : LANES packed metrics, lane k at [(k+1)*(M+1)-1 : k*(M+1)]
//   out_valid                 : one-cycle result pulse
//   out_index/out_min         : global argmin index and its metric
//   out_err                   : sticky protocol error
// master = beat source, slave = argmin block.
interface pm_argmin_stream_if
    import pm_argmin_stream_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int LANES      = DEF_LANES,
    parameter int LOG2_LANES = DEF_LOG2_LANES,
    parameter int BEAT_W     = DEF_BEAT_W
);
    logic                           in_valid;
    logic                           in_first;
    logic                           in_last;
    logic [LANES*(M+1)-1:0]         in_metrics;
    logic                           out_valid;
    logic [BEAT_W+LOG2_LANES-1:0]   out_index;
    logic [M:0]                     out_min;
    logic                           out_err;

    modport master (
        output in_valid, in_first, in_last, in_metrics,
        input  out_valid, out_index, out_min, out_err
    );

    modport slave (
        input  in_valid, in_first, in_last, in_metrics,
        output out_valid, out_index, out_min, out_err
    );
endinterface

// File: rtl/pm_argmin_stream_min2_sel.sv
// min2_sel: combinational compare-select of two (value, index) pairs.
//   a_* : pair from the lower lane, b_* : pair from the upper lane
//   y_* : b wins only when strictly smaller, so ties keep the lower index
module min2_sel
    import pm_argmin_stream_pkg::*;
#(
    parameter int VAL_W = METRIC_W,
    parameter int IDX_W = DEF_LOG2_LANES
) (
    input  logic [VAL_W-1:0] a_val_i,
    input  logic [IDX_W-1:0] a_idx_i,
    input  logic [VAL_W-1:0] b_val_i,
    input  logic [IDX_W-1:0] b_idx_i,
    output logic [VAL_W-1:0] y_val_o,
    output logic [IDX_W-1:0] y_idx_o
);
    logic b_wins;

    always_comb begin
        b_wins  = (b_val_i < a_val_i);
        y_val_o = b_wins ? b_val_i : a_val_i;
        y_idx_o = b_wins ? b_idx_i : a_idx_i;
    end
endmodule

// File: rtl/pm_argmin_stream.sv
// pm_argmin_stream: pipelined multi-beat argmin over path metrics.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pm_argmin_stream_if (beats in, result out)
// Pipeline: input stage (frame tracking, beat numbering) -> LOG2_LANES
// registered compare levels -> accumulator/output register. A result
// appears LOG2_LANES+1 cycles after the edge accepting the last beat.
module pm_argmin_stream
    import pm_argmin_stream_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int LANES      = DEF_LANES,
    parameter int LOG2_LANES = DEF_LOG2_LANES,
    parameter int MAX_BEATS  = DEF_MAX_BEATS,
    parameter int BEAT_W     = DEF_BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    pm_argmin_stream_if.slave bus
);
    localparam int MW    = M + 1;
    localparam int LW    = LOG2_LANES;
    localparam int IDX_W = BEAT_W + LOG2_LANES;
    localparam int NODES = LANES - 1;

    typedef logic [MW-1:0]     val_t;
    typedef logic [LW-1:0]     lane_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [IDX_W-1:0]  gidx_t;

    localparam beat_t BEAT_MAX = beat_t'(MAX_BEATS - 1);

    // ---------------- input stage ----------------
    logic                   open_q, open_d;
    beat_t                  cnt_q, cnt_d;
    logic                   err_q, err_d;
    beat_t                  beat_d;
    beat_kind_e             kind;
    logic [LANES*MW-1:0]    s0_metrics_q;

    // Sideband pipes: index 0 is the input stage, index LW the last tree level.
    logic [LW:0]            vld_q;
    logic [LW:0]            first_q;
    logic [LW:0]            last_q;
    beat_t                  beat_q [LW+1];

    always_comb begin
        kind = KIND_IDLE;
        if (bus.in_valid) begin
            if (bus.in_first)  kind = KIND_FIRST;
            else if (open_q)   kind = KIND_NEXT;
            else               kind = KIND_DROP;
        end

        beat_d = '0;
        cnt_d  = cnt_q;
        open_d = open_q;
        err_d  = err_q;
        case (kind)
            KIND_FIRST: begin
                cnt_d  = '0;
                open_d = !bus.in_last;
            end
            KIND_NEXT: begin
                // Overlong frame: keep numbering the extra beats as the last slot.
                if (cnt_q == BEAT_MAX) begin
                    beat_d = cnt_q;
                    err_d  = 1'b1;
                end else begin
                    beat_d = cnt_q + beat_t'(1);
                end
                cnt_d  = beat_d;
                open_d = !bus.in_last;
            end
            KIND_DROP: err_d = 1'b1;
            default: ;
        endcase
    end

    // ---------------- compare tree ----------------
    // Node storage is flattened level by level: level l (1..LW) occupies
    // LANES>>l nodes starting at LANES - (LANES >> (l-1)).
    val_t  sel_val [NODES];
    lane_t sel_idx [NODES];
    val_t  nval_q  [NODES];
    lane_t nidx_q  [NODES];

    for (genvar l = 1; l <= LW; l++) begin : g_lvl
        localparam int N   = LANES >> l;
        localparam int OFF = LANES - (LANES >> (l - 1));
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 1) begin : g_leaf
                min2_sel #(.VAL_W(MW), .IDX_W(LW)) u_min (
                    .a_val_i (s0_metrics_q[(2*j)*MW +: MW]),
                    .a_idx_i (lane_t'(2*j)),
                    .b_val_i (s0_metrics_q[(2*j+1)*MW +: MW]),
                    .b_idx_i (lane_t'(2*j+1)),
                    .y_val_o (sel_val[OFF+j]),
                    .y_idx_o (sel_idx[OFF+j])
                );
            end else begin : g_inner
                localparam int POFF = LANES - (LANES >> (l - 2));
                min2_sel #(.VAL_W(MW), .IDX_W(LW)) u_min (
                    .a_val_i (nval_q[POFF+2*j]),
                    .a_idx_i (nidx_q[POFF+2*j]),
                    .b_val_i (nval_q[POFF+2*j+1]),
                    .b_idx_i (nidx_q[POFF+2*j+1]),
                    .y_val_o (sel_val[OFF+j]),
                    .y_idx_o (sel_idx[OFF+j])
                );
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            s0_metrics_q <= '0;
            vld_q        <= '0;
            first_q      <= '0;
            last_q       <= '0;
            for (int unsigned i = 0; i <= LW; i++) beat_q[i] <= '0;
            for (int unsigned n = 0; n < NODES; n++) begin
                nval_q[n] <= '0;
                nidx_q[n] <= '0;
            end
        end else begin
            open_q       <= open_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            s0_metrics_q <= bus.in_metrics;
            vld_q[0]     <= (kind == KIND_FIRST) || (kind == KIND_NEXT);
            first_q[0]   <= bus.in_first;
            last_q[0]    <= bus.in_last;
            beat_q[0]    <= beat_d;
            for (int unsigned i = 1; i <= LW; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                beat_q[i]  <= beat_q[i-1];
            end
            for (int unsigned n = 0; n < NODES; n++) begin
                nval_q[n] <= sel_val[n];
                nidx_q[n] <= sel_idx[n];
            end
        end
    end

    // ---------------- accumulator / output ----------------
    val_t  acc_val_q, acc_val_d;
    gidx_t acc_idx_q, acc_idx_d;
    logic  take;
    logic  out_valid_q;
    gidx_t out_index_q;
    val_t  out_min_q;

    // Strict less-than keeps the earlier beat on ties (lowest global index).
    always_comb begin
        take      = vld_q[LW] && (first_q[LW] || (nval_q[NODES-1] < acc_val_q));
        acc_val_d = take ? nval_q[NODES-1] : acc_val_q;
        acc_idx_d = take ? {beat_q[LW], nidx_q[NODES-1]} : acc_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_val_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_min_q   <= '0;
        end else begin
            acc_val_q   <= acc_val_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= vld_q[LW] && last_q[LW];
            if (vld_q[LW] && last_q[LW]) begin
                out_index_q <= acc_idx_d;
                out_min_q   <= acc_val_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_pm_argmin_stream.sv
module tb_pm_argmin_stream;

    localparam int A_L = 8;   // default configuration: 7-bit metrics, 8 lanes, 8 beats
    localparam int B_L = 4;   // sweep configuration: 8-bit metrics, 4 lanes, 4 beats
    localparam int B_MAXB = 4;
    localparam int B_LAT = 3; // LOG2_LANES+1 for the sweep instance

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pm_argmin_stream_if #(.M(6), .LANES(8), .LOG2_LANES(3), .BEAT_W(3)) ifA ();
    pm_argmin_stream_if #(.M(7), .LANES(4), .LOG2_LANES(2), .BEAT_W(2)) ifB ();

    pm_argmin_stream #(.M(6), .LANES(8), .LOG2_LANES(3), .MAX_BEATS(8), .BEAT_W(3)) dutA (
        .clk(clk), .rst(rst), .bus(ifA)
    );
    pm_argmin_stream #(.M(7), .LANES(4), .LOG2_LANES(2), .MAX_BEATS(4), .BEAT_W(2)) dutB (
        .clk(clk), .rst(rst), .bus(ifB)
    );

    int vectors = 0;
    int miscompares = 0;
    int pulsesA = 0;
    int bm [A_L];

    task automatic tick();
        @(posedge clk);
        #1;
        if (ifA.out_valid === 1'b1) pulsesA++;
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < A_L; k++) bm[k] = v;
    endtask

    task automatic put_a(input bit v, input bit f, input bit l);
        ifA.in_valid = v;
        ifA.in_first = f;
        ifA.in_last  = l;
        for (int k = 0; k < A_L; k++) ifA.in_metrics[k*7 +: 7] = 7'(bm[k]);
    endtask

    task automatic idle_b();
        ifB.in_valid   = 1'b0;
        ifB.in_first   = 1'b0;
        ifB.in_last    = 1'b0;
        ifB.in_metrics = '0;
    endtask

    task automatic test_reset();
        fill(0);
        put_a(0, 0, 0);
        idle_b();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++; if (ifA.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ifA.out_valid); end
        vectors++; if (ifA.out_index !== 6'd0) begin miscompares++; $display("FAIL reset_index: got %0d want 0", ifA.out_index); end
        vectors++; if (ifA.out_min !== 7'd0) begin miscompares++; $display("FAIL reset_min: got %0d want 0", ifA.out_min); end
        vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", ifA.out_err); end
        vectors++; if (ifB.out_valid !== 1'b0 || ifB.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_b: got v=%b e=%b want 0 0", ifB.out_valid, ifB.out_err); end
    endtask

    task automatic test_single_beat();
        bm[0] = 9; bm[1] = 4; bm[2] = 7; bm[3] = 4; bm[4] = 12; bm[5] = 30; bm[6] = 5; bm[7] = 6;
        put_a(1, 1, 1);
        tick();
        put_a(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                vectors++; if (ifA.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: cycle %0d got %b want 0", k, ifA.out_valid); end
            end else begin
                vectors++; if (ifA.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", ifA.out_valid); end
                vectors++; if (ifA.out_index !== 6'd1) begin miscompares++; $display("FAIL single_index: got %0d want 1", ifA.out_index); end
                vectors++; if (ifA.out_min !== 7'd4) begin miscompares++; $display("FAIL single_min: got %0d want 4", ifA.out_min); end
            end
        end
        tick();
        vectors++; if (ifA.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse_width: got %b want 0", ifA.out_valid); end
    endtask

    task automatic test_multi_beat();
        for (int b = 0; b < 4; b++) begin
            fill(20);
            if (b == 2) bm[5] = 3;
            if (b == 3) bm[0] = 3;
            put_a(1, b == 0, b == 3);
            tick();
        end
        put_a(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                vectors++; if (ifA.out_valid !== 1'b0) begin miscompares++; $display("FAIL multi_early: cycle %0d got %b want 0", k, ifA.out_valid); end
            end
        end
        vectors++; if (ifA.out_valid !== 1'b1) begin miscompares++; $display("FAIL multi_valid: got %b want 1", ifA.out_valid); end
        vectors++; if (ifA.out_index !== 6'd21) begin miscompares++; $display("FAIL multi_index: got %0d want 21", ifA.out_index); end
        vectors++; if (ifA.out_min !== 7'd3) begin miscompares++; $display("FAIL multi_min: got %0d want 3", ifA.out_min); end
        vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL multi_err: got %b want 0", ifA.out_err); end
    endtask

    task automatic test_back_to_back();
        fill(9); bm[3] = 2;
        put_a(1, 1, 1);
        tick();
        fill(9); bm[5] = 1;
        put_a(1, 1, 1);
        tick();
        put_a(0, 0, 0);
        tick(); tick(); tick();
        vectors++; if (ifA.out_valid !== 1'b1 || ifA.out_index !== 6'd3 || ifA.out_min !== 7'd2) begin
            miscompares++; $display("FAIL b2b_first: got v=%b idx=%0d min=%0d want 1 3 2", ifA.out_valid, ifA.out_index, ifA.out_min); end
        tick();
        vectors++; if (ifA.out_valid !== 1'b1 || ifA.out_index !== 6'd5 || ifA.out_min !== 7'd1) begin
            miscompares++; $display("FAIL b2b_second: got v=%b idx=%0d min=%0d want 1 5 1", ifA.out_valid, ifA.out_index, ifA.out_min); end
        tick();
    endtask

    task automatic test_abandon();
        int p0;
        p0 = pulsesA;
        fill(40); put_a(1, 1, 0); tick();
        fill(40); bm[2] = 1; put_a(1, 0, 0); tick();
        fill(10); put_a(1, 1, 1); tick();
        put_a(0, 0, 0);
        tick(); tick(); tick(); tick();
        vectors++; if (ifA.out_valid !== 1'b1 || ifA.out_index !== 6'd0 || ifA.out_min !== 7'd10) begin
            miscompares++; $display("FAIL abandon_result: got v=%b idx=%0d min=%0d want 1 0 10", ifA.out_valid, ifA.out_index, ifA.out_min); end
        for (int k = 0; k < 6; k++) tick();
        vectors++; if (pulsesA - p0 !== 1) begin miscompares++; $display("FAIL abandon_pulses: got %0d want 1", pulsesA - p0); end
        vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL abandon_err: got %b want 0", ifA.out_err); end
    endtask

    task automatic test_mid_reset();
        int p0;
        fill(30); bm[6] = 1;
        put_a(1, 1, 1);
        tick();
        put_a(0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p0 = pulsesA;
        vectors++; if (ifA.out_valid !== 1'b0 || ifA.out_index !== 6'd0 || ifA.out_min !== 7'd0 || ifA.out_err !== 1'b0) begin
            miscompares++; $display("FAIL midrst_outputs: got v=%b idx=%0d min=%0d e=%b want all 0", ifA.out_valid, ifA.out_index, ifA.out_min, ifA.out_err); end
        for (int k = 0; k < 8; k++) tick();
        vectors++; if (pulsesA - p0 !== 0) begin miscompares++; $display("FAIL midrst_pulses: got %0d want 0", pulsesA - p0); end
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 9; b++) begin
            fill(50);
            if (b == 8) bm[2] = 0;
            put_a(1, b == 0, b == 8);
            tick();
            if (b == 7) begin
                vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_at_max: got %b want 0", ifA.out_err); end
            end
        end
        put_a(0, 0, 0);
        tick(); tick(); tick(); tick();
        vectors++; if (ifA.out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %b want 1", ifA.out_valid); end
        vectors++; if (ifA.out_index !== 6'd58) begin miscompares++; $display("FAIL ovf_index: got %0d want 58", ifA.out_index); end
        vectors++; if (ifA.out_min !== 7'd0) begin miscompares++; $display("FAIL ovf_min: got %0d want 0", ifA.out_min); end
        vectors++; if (ifA.out_err !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", ifA.out_err); end
    endtask

    task automatic test_orphan_last();
        int p0;
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL orphan_pre_err: got %b want 0", ifA.out_err); end
        p0 = pulsesA;
        fill(2);
        put_a(1, 0, 1);
        tick();
        put_a(0, 0, 0);
        for (int k = 0; k < 6; k++) tick();
        vectors++; if (pulsesA - p0 !== 0) begin miscompares++; $display("FAIL orphan_pulses: got %0d want 0", pulsesA - p0); end
        vectors++; if (ifA.out_err !== 1'b1) begin miscompares++; $display("FAIL orphan_err: got %b want 1", ifA.out_err); end
        for (int k = 0; k < 4; k++) tick();
        vectors++; if (ifA.out_err !== 1'b1) begin miscompares++; $display("FAIL orphan_sticky: got %b want 1", ifA.out_err); end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if (ifA.out_err !== 1'b0) begin miscompares++; $display("FAIL orphan_clear: got %b want 0", ifA.out_err); end
    endtask

    // Reference argmin over a whole frame: beats scanned in order, lanes in
    // order, strict less-than, beats past the limit share the last beat slot.
    function automatic void argmin_ref(input int q[$], output int idx, output int mn);
        int nb;
        int bslot;
        nb  = q.size() / B_L;
        mn  = q[0];
        idx = 0;
        for (int b = 0; b < nb; b++) begin
            bslot = (b < B_MAXB) ? b : B_MAXB - 1;
            for (int l = 0; l < B_L; l++) begin
                if (q[b*B_L + l] < mn) begin
                    mn  = q[b*B_L + l];
                    idx = bslot * B_L + l;
                end
            end
        end
    endfunction

    task automatic test_sweep_random();
        int fq[$];
        int ecyc[$];
        int eidx[$];
        int emin[$];
        bit open_m;
        bit err_m;
        int cyc;
        bit v, f, l;
        int m[B_L];
        int ri, rm;
        bit expv;
        for (int seg = 0; seg < 8; seg++) begin
            idle_b();
            rst = 1'b1; tick(); rst = 1'b0;
            fq.delete(); ecyc.delete(); eidx.delete(); emin.delete();
            open_m = 1'b0; err_m = 1'b0; cyc = 0;
            for (int n = 0; n < 90; n++) begin
                if (n < 80) begin
                    v = ($urandom_range(0, 3) != 0);
                    f = open_m ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
                    l = ($urandom_range(0, 3) == 0);
                    for (int k = 0; k < B_L; k++)
                        m[k] = (seg % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
                end else begin
                    v = 1'b0; f = 1'b0; l = 1'b0;
                    for (int k = 0; k < B_L; k++) m[k] = 0;
                end
                ifB.in_valid = v;
                ifB.in_first = f;
                ifB.in_last  = l;
                for (int k = 0; k < B_L; k++) ifB.in_metrics[k*8 +: 8] = 8'(m[k]);
                if (v) begin
                    if (f) begin
                        fq.delete();
                        for (int k = 0; k < B_L; k++) fq.push_back(m[k]);
                        open_m = !l;
                    end else if (open_m) begin
                        if (fq.size() / B_L >= B_MAXB) err_m = 1'b1;
                        for (int k = 0; k < B_L; k++) fq.push_back(m[k]);
                        open_m = !l;
                    end else begin
                        err_m = 1'b1;
                    end
                    if (l && (f || fq.size() > 0) && !open_m && (f || fq.size() >= B_L)) begin
                        if (f || open_m == 1'b0) begin
                            // frame closed by this beat only if it was accepted
                        end
                    end
                end
                if (v && l && (f || (fq.size() > 0 && !open_m && ecyc.size() >= 0))) begin
                    // a last beat that was accepted closes the frame it belongs to
                end
                if (v && l && fq.size() > 0 && !open_m) begin
                    argmin_ref(fq, ri, rm);
                    ecyc.push_back(cyc + 1 + B_LAT);
                    eidx.push_back(ri);
                    emin.push_back(rm);
                    fq.delete();
                end
                tick();
                cyc++;
                expv = (ecyc.size() > 0) && (ecyc[0] == cyc);
                vectors++;
                if (ifB.out_valid !== expv) begin
                    miscompares++; $display("FAIL sweep_valid: seg %0d cycle %0d got %b want %b", seg, cyc, ifB.out_valid, expv);
                end else if (expv) begin
                    vectors++;
                    if (ifB.out_index !== 4'(eidx[0]) || ifB.out_min !== 8'(emin[0])) begin
                        miscompares++; $display("FAIL sweep_result: seg %0d cycle %0d got idx=%0d min=%0d want idx=%0d min=%0d",
                                                seg, cyc, ifB.out_index, ifB.out_min, eidx[0], emin[0]);
                    end
                end
                if (expv) begin
                    void'(ecyc.pop_front()); void'(eidx.pop_front()); void'(emin.pop_front());
                end
            end
            vectors++; if (ifB.out_err !== err_m) begin miscompares++; $display("FAIL sweep_err: seg %0d got %b want %b", seg, ifB.out_err, err_m); end
            vectors++; if (ecyc.size() !== 0) begin miscompares++; $display("FAIL sweep_missing: seg %0d got %0d results outstanding want 0", seg, ecyc.size()); end
        end
        idle_b();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_abandon();
        test_mid_reset();
        test_overflow();
        test_orphan_last();
        test_sweep_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
